pwm_duty_ramp_ctrl: RTL and testbench

- Sequences the 8-bit duty-cycle input of the PWM output stage.
- Accepts queued ramp commands (target, step size, step interval) over a valid/ready handshake.
- Slews its duty output toward each target, one step per programmed number of PWM periods.
- Sits between the register/command front end and the PWM peripheral; its duty output drives the peripheral's duty-cycle input.

---
 rtl/pwm_duty_ramp_ctrl.sv | 147 ++++++++++++++
 tb/tb_pwm_duty_ramp_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ramp_ctrl.sv
// Slews the PWM duty output toward queued {target, step, rate} commands, one step per N PWM periods.
// Commands wait in a 2-deep queue; abort flushes the queue and freezes the duty where it is.
module pwm_duty_ramp_ctrl #(
  parameter int PERIOD_CLKS = 3328
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_target,
  input  logic [3:0] cmd_step,
  input  logic [3:0] cmd_rate,
  input  logic       abort,
  output logic [7:0] duty_out,
  output logic       busy,
  output logic       done,
  output logic [1:0] queue_level
);

  localparam int CW = $clog2(PERIOD_CLKS);

  typedef struct packed {
    logic [7:0] target;
    logic [3:0] step;
    logic [3:0] rate;
  } cmd_t;

  typedef enum logic {IDLE, RAMP} state_t;

  logic [CW-1:0] per_cnt;
  logic          tick;

  cmd_t          q [2];
  cmd_t          cmd_in;
  cmd_t          act;
  logic [1:0]    level;
  logic          push;
  logic          pop;

  state_t        state, state_nxt;
  logic [7:0]    duty_nxt;
  logic [3:0]    wait_cnt, wait_nxt;
  logic          done_nxt;
  logic [8:0]    sum, diff;

  // Period counter runs freely; commands and abort never disturb its phase.
  assign tick = (per_cnt == CW'(PERIOD_CLKS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt <= '0;
    end else if (tick) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + CW'(1);
    end
  end

  assign cmd_in    = {cmd_target, cmd_step, cmd_rate};
  assign cmd_ready = (level < 2'd2) && !abort && !rst;
  assign push      = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      level <= '0;
    end else begin
      level <= level + {1'b0, push} - {1'b0, pop};
    end
  end

  // Push together with pop can only happen at level 1, so the new entry becomes the head.
  always_ff @(posedge clk) begin
    if (pop) begin
      q[0] <= push ? cmd_in : q[1];
    end else if (push) begin
      q[level[0]] <= cmd_in;
    end
  end

  assign sum  = {1'b0, duty_out} + {5'b0, act.step};
  assign diff = {1'b0, duty_out} - {5'b0, act.step};

  always_comb begin
    state_nxt = state;
    duty_nxt  = duty_out;
    wait_nxt  = wait_cnt;
    done_nxt  = 1'b0;
    pop       = 1'b0;
    if (rst || abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (level != 2'd0) begin
            pop       = 1'b1;
            wait_nxt  = q[0].rate;
            state_nxt = RAMP;
            if (q[0].step == 4'd0) begin
              duty_nxt = q[0].target;
            end
          end
        end
        RAMP: begin
          // Target check comes first so a reached target finishes without waiting for a tick.
          if (duty_out == act.target) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else if (tick) begin
            if (wait_cnt == 4'd0) begin
              wait_nxt = act.rate;
              if (duty_out < act.target) begin
                duty_nxt = (sum > {1'b0, act.target}) ? act.target : sum[7:0];
              end else begin
                duty_nxt = (diff[8] || (diff[7:0] < act.target)) ? act.target : diff[7:0];
              end
            end else begin
              wait_nxt = wait_cnt - 4'd1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      duty_out <= '0;
      wait_cnt <= '0;
      done     <= 1'b0;
      act      <= '0;
    end else begin
      state    <= state_nxt;
      duty_out <= duty_nxt;
      wait_cnt <= wait_nxt;
      done     <= done_nxt;
      if (pop) begin
        act <= q[0];
      end
    end
  end

  assign busy        = (state == RAMP) || (level != 2'd0);
  assign queue_level = level;

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Directed bench for pwm_duty_ramp_ctrl with an 8-clock PWM period.
module tb_pwm_duty_ramp_ctrl;
  localparam int P = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_target;
  logic [3:0] cmd_step;
  logic [3:0] cmd_rate;
  logic       abort;
  logic [7:0] duty_out;
  logic       busy;
  logic       done;
  logic [1:0] queue_level;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int r_edge  = 0;

  typedef struct {
    logic [7:0] target;
    logic [3:0] step;
    logic [3:0] rate;
    int         n_upd;
    logic [7:0] first_v;
    logic [7:0] last_v;
  } vec_t;

  vec_t vt [8];

  pwm_duty_ramp_ctrl #(.PERIOD_CLKS(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_step   (cmd_step),
    .cmd_rate   (cmd_rate),
    .abort      (abort),
    .duty_out   (duty_out),
    .busy       (busy),
    .done       (done),
    .queue_level(queue_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pushes one command, tracks every duty change until done, checks values and tick alignment.
  task automatic run_cmd(input vec_t v, input int idx);
    int push_e, pop_e, n, first_e, last_e, done_e, bad_int, t1, exp_first_e;
    logic [7:0] prev, fv, lv;
    n = 0; bad_int = 0; done_e = -1; first_e = -1; last_e = -1;
    prev = duty_out; fv = '0; lv = '0;
    cmd_target = v.target; cmd_step = v.step; cmd_rate = v.rate; cmd_valid = 1'b1;
    #1;
    check($sformatf("v%0d_ready", idx), cmd_ready, 1);
    @(negedge clk);
    push_e = cyc;
    cmd_valid = 1'b0;
    for (int k = 0; k < 400 && done_e < 0; k++) begin
      if (duty_out !== prev) begin
        if (n == 0) begin
          first_e = cyc; fv = duty_out;
        end else if (cyc - last_e != P * (int'(v.rate) + 1)) begin
          bad_int++;
        end
        last_e = cyc; lv = duty_out; n++; prev = duty_out;
      end
      if (done === 1'b1) done_e = cyc;
      else @(negedge clk);
    end
    pop_e = push_e + 1;
    if (v.step == 4'd0) begin
      exp_first_e = pop_e;
    end else begin
      t1 = r_edge + P * ((pop_e - r_edge) / P + 1);
      exp_first_e = t1 + P * int'(v.rate);
    end
    check($sformatf("v%0d_nupd", idx), n, v.n_upd);
    if (v.n_upd > 0) begin
      check($sformatf("v%0d_first_val", idx), fv, v.first_v);
      check($sformatf("v%0d_last_val", idx), lv, v.last_v);
      check($sformatf("v%0d_first_edge", idx), first_e, exp_first_e);
      check($sformatf("v%0d_bad_intervals", idx), bad_int, 0);
      check($sformatf("v%0d_done_edge", idx), done_e, last_e + 1);
    end else begin
      check($sformatf("v%0d_done_edge", idx), done_e, push_e + 2);
    end
    check($sformatf("v%0d_busy_at_done", idx), busy, 0);
    @(negedge clk);
    check($sformatf("v%0d_done_width", idx), done, 0);
  endtask

  initial begin
    int nd, dones_at_acc, lvl_at_acc, n_done, n_chg, n_lvl;
    logic [7:0] dv [4];
    logic [7:0] hold_v;
    vec_t tmp;

    vt[0] = '{8'h03, 4'd1,  4'd0, 3,  8'h01, 8'h03};
    vt[1] = '{8'hF0, 4'd0,  4'd0, 1,  8'hF0, 8'hF0};
    vt[2] = '{8'hFF, 4'd10, 4'd1, 2,  8'hFA, 8'hFF};
    vt[3] = '{8'h02, 4'd15, 4'd0, 17, 8'hF0, 8'h02};
    vt[4] = '{8'h00, 4'd0,  4'd0, 1,  8'h00, 8'h00};
    vt[5] = '{8'h80, 4'd0,  4'd0, 1,  8'h80, 8'h80};
    vt[6] = '{8'h80, 4'd5,  4'd3, 0,  8'h00, 8'h00};
    vt[7] = '{8'h70, 4'd15, 4'd2, 2,  8'h71, 8'h70};

    rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_target = '0; cmd_step = '0; cmd_rate = '0;
    repeat (3) @(negedge clk);
    check("rst_duty", duty_out, 0);
    check("rst_done", done, 0);
    check("rst_level", queue_level, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 0);
    r_edge = cyc;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_cmd(vt[i], i);

    // Back-to-back commands: queue fills, fourth waits for a pop.
    cmd_target = 8'h74; cmd_step = 4'd1; cmd_rate = 4'd0; cmd_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("b2b_busy", busy, 1);
    check("b2b_level0", queue_level, 0);
    cmd_target = 8'h10; cmd_step = 4'd0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_target = 8'h20;
    @(negedge clk);
    check("b2b_level2", queue_level, 2);
    cmd_target = 8'h30;
    #1;
    check("b2b_ready_full", cmd_ready, 0);
    nd = 0; dones_at_acc = -1; lvl_at_acc = -1;
    for (int k = 0; k < 4; k++) dv[k] = '0;
    for (int k = 0; k < 300 && nd < 4; k++) begin
      if (done === 1'b1) begin
        dv[nd] = duty_out; nd++;
      end
      if (cmd_valid && cmd_ready) begin
        dones_at_acc = nd; lvl_at_acc = queue_level;
        @(negedge clk); cmd_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    check("b2b_ndone", nd, 4);
    check("b2b_acc_after_done", dones_at_acc, 1);
    check("b2b_acc_level", lvl_at_acc, 1);
    check("b2b_done0", dv[0], 8'h74);
    check("b2b_done1", dv[1], 8'h10);
    check("b2b_done2", dv[2], 8'h20);
    check("b2b_done3", dv[3], 8'h30);
    check("b2b_final", duty_out, 8'h30);
    @(negedge clk);

    // Abort mid-ramp with one queued command and a coincident push.
    tmp = '{8'h05, 4'd0, 4'd0, 1, 8'h05, 8'h05};
    run_cmd(tmp, 8);
    cmd_target = 8'h40; cmd_step = 4'd4; cmd_rate = 4'd7; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_target = 8'h50; cmd_step = 4'd0; cmd_rate = 4'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("abt_level_pre", queue_level, 1);
    check("abt_busy_pre", busy, 1);
    abort = 1'b1; cmd_valid = 1'b1; cmd_target = 8'h60;
    #1;
    check("abt_ready", cmd_ready, 0);
    @(negedge clk);
    abort = 1'b0; cmd_valid = 1'b0;
    check("abt_level", queue_level, 0);
    check("abt_duty", duty_out, 8'h05);
    check("abt_done", done, 0);
    check("abt_busy", busy, 0);
    n_done = 0; n_chg = 0; n_lvl = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done !== 1'b0) n_done++;
      if (duty_out !== 8'h05) n_chg++;
      if (queue_level !== 2'd0) n_lvl++;
    end
    check("abt_no_done", n_done, 0);
    check("abt_duty_held", n_chg, 0);
    check("abt_queue_empty", n_lvl, 0);

    // Reset mid-ramp with a queued command.
    cmd_target = 8'h40; cmd_step = 4'd1; cmd_rate = 4'd0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_target = 8'h90; cmd_step = 4'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    hold_v = duty_out;
    for (int k = 0; k < 40 && hold_v == 8'h05; k++) begin
      @(negedge clk);
      hold_v = duty_out;
    end
    check("rmid_duty", duty_out, 8'h06);
    check("rmid_level", queue_level, 1);
    rst = 1'b1;
    #1;
    check("rmid_ready_in_rst", cmd_ready, 0);
    @(negedge clk);
    check("rmid_duty0", duty_out, 0);
    check("rmid_level0", queue_level, 0);
    check("rmid_done0", done, 0);
    check("rmid_busy0", busy, 0);
    check("rmid_ready0", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rmid_ready_release", cmd_ready, 1);
    n_chg = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (duty_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) n_chg++;
    end
    check("rmid_quiet", n_chg, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
